buyruk_onbellegi: RTL and testbench

Direct-mapped L1 instruction cache (l1b). It is the responder side of the fetch interface driven by `getir`: it accepts program-counter requests, returns 32-bit instruction words, and stalls the fetch stage on a miss while it refills a block word by word from the memory side. It sits between `getir` and the memory/bus interface, one instance per core.

---
 rtl/buyruk_onbellegi_if.sv | 24 ++
 rtl/buyruk_onbellegi.sv | 113 +++++++++++
 tb/tb_buyruk_onbellegi.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/buyruk_onbellegi_if.sv
// Fetch/refill bundle of the L1 instruction cache: the getir request side and
// the memory refill side. The cache is the slave; getir plus memory form the master.
interface buyruk_onbellegi_if;
  logic [31:0] ps_i;
  logic        ps_gecerli_i;
  logic        hazir_o;
  logic [31:0] buyruk_o;
  logic        buyruk_gecerli_o;
  logic        gecersiz_kil_i;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic [31:0] bellek_veri_i;
  logic        bellek_veri_gecerli_i;

  modport slave (
    input  ps_i, ps_gecerli_i, gecersiz_kil_i, bellek_veri_i, bellek_veri_gecerli_i,
    output hazir_o, buyruk_o, buyruk_gecerli_o, bellek_istek_o, bellek_adres_o
  );

  modport master (
    output ps_i, ps_gecerli_i, gecersiz_kil_i, bellek_veri_i, bellek_veri_gecerli_i,
    input  hazir_o, buyruk_o, buyruk_gecerli_o, bellek_istek_o, bellek_adres_o
  );
endinterface

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped, read-only L1 instruction cache. Hits answer in one cycle;
// misses stall getir and refill the whole line word by word from memory.
module buyruk_onbellegi #(
  parameter int SATIR_SAYISI = 64,
  parameter int BLOK_KELIME  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  buyruk_onbellegi_if.slave   bus
);
  localparam int KW = $clog2(BLOK_KELIME);
  localparam int IW = $clog2(SATIR_SAYISI);
  localparam int OW = KW + 2;
  localparam int TW = 32 - OW - IW;

  localparam logic [0:0]    BOSTA  = 1'b0;
  localparam logic [0:0]    DOLDUR = 1'b1;
  localparam logic [KW-1:0] SON    = KW'(BLOK_KELIME - 1);

  logic [0:0]              durum;
  logic [SATIR_SAYISI-1:0] gecerli;
  logic [TW-1:0]           etiket [SATIR_SAYISI];
  logic [31:0]             veri   [SATIR_SAYISI][BLOK_KELIME];
  logic [KW-1:0]           sayac;
  logic                    bekleyen_kil;

  // Captured miss address, split into its fields.
  logic [TW-1:0] y_etiket;
  logic [IW-1:0] y_satir;
  logic [KW-1:0] y_kelime;

  logic [TW-1:0] ps_etiket;
  logic [IW-1:0] ps_satir;
  logic [KW-1:0] ps_kelime;
  logic          isabet;
  logic          son_vurus;
  logic          unused_ok;

  assign ps_etiket = bus.ps_i[31 -: TW];
  assign ps_satir  = bus.ps_i[OW +: IW];
  assign ps_kelime = bus.ps_i[2 +: KW];
  assign unused_ok = &{1'b0, bus.ps_i[1:0]};

  assign isabet    = gecerli[ps_satir] && (etiket[ps_satir] == ps_etiket);
  assign son_vurus = (durum == DOLDUR) && bus.bellek_veri_gecerli_i && (sayac == SON);

  assign bus.hazir_o        = (durum == BOSTA) && !bus.gecersiz_kil_i && !rst_i;
  assign bus.bellek_istek_o = (durum == DOLDUR);
  assign bus.bellek_adres_o = (durum == DOLDUR) ? {y_etiket, y_satir, sayac, 2'b00} : 32'h0;

  // NOTE: every register written here uses <=, so all reads in this block see
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum                <= BOSTA;
      gecerli              <= '0;
      sayac                <= '0;
      bekleyen_kil         <= 1'b0;
      y_etiket             <= '0;
      y_satir              <= '0;
      y_kelime             <= '0;
      bus.buyruk_o         <= 32'h0;
      bus.buyruk_gecerli_o <= 1'b0;
    end else begin
      bus.buyruk_gecerli_o <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bus.gecersiz_kil_i) begin
            gecerli <= '0;
          end else if (bus.ps_gecerli_i) begin
            if (isabet) begin
              bus.buyruk_o         <= veri[ps_satir][ps_kelime];
              bus.buyruk_gecerli_o <= 1'b1;
            end else begin
              y_etiket <= ps_etiket;
              y_satir  <= ps_satir;
              y_kelime <= ps_kelime;
              sayac    <= '0;
              durum    <= DOLDUR;
            end
          end
        end
        default: begin
          if (bus.gecersiz_kil_i) bekleyen_kil <= 1'b1;
          if (bus.bellek_veri_gecerli_i) sayac <= sayac + 1'b1;
          if (son_vurus) begin
            durum                <= BOSTA;
            bus.buyruk_gecerli_o <= 1'b1;
            bus.buyruk_o         <= (y_kelime == SON) ? bus.bellek_veri_i
                                                      : veri[y_satir][y_kelime];
            // A fence.i seen during the refill wipes every line, including the
            // one just filled, so nothing stale survives into the next request.
            if (bekleyen_kil || bus.gecersiz_kil_i) begin
              gecerli      <= '0;
              bekleyen_kil <= 1'b0;
            end else begin
              gecerli[y_satir] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide
  // whether their contents are meaningful.
  always_ff @(posedge clk_i) begin
    if ((durum == DOLDUR) && bus.bellek_veri_gecerli_i) begin
      veri[y_satir][sayac] <= bus.bellek_veri_i;
      if (sayac == SON) etiket[y_satir] <= y_etiket;
    end
  end
endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Self-checking bench for buyruk_onbellegi: directed fill/hit/conflict/fence/reset
// sequences plus randomized requests checked against a line-level cache model.
module tb_buyruk_onbellegi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buyruk_onbellegi_if bus ();

  buyruk_onbellegi #(.SATIR_SAYISI(64), .BLOK_KELIME(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit mem_on   = 1'b1;
  int stall_pct = 0;

  // Reference model: one valid flag and one tag per line.
  bit          m_gecerli [64];
  logic [21:0] m_etiket  [64];

  typedef struct {
    logic [31:0] adres;
    logic [31:0] kelime;
  } vektor_t;
  vektor_t tablo [5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'h11111111 * ({30'b0, a[3:2]} + 32'd1);
    return ((a & 32'hFFFF_FFFC) ^ 32'hDEAD_BEEF) * 32'h9E37_79B1;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_gecerli[i] = 1'b0;
  endtask

  // Memory side: returns the word at bellek_adres_o, with optional random stalls.
  always @(negedge clk) begin
    if (bus.bellek_istek_o && mem_on && ($urandom_range(0, 99) >= stall_pct)) begin
      bus.bellek_veri_gecerli_i = 1'b1;
      bus.bellek_veri_i         = mem_word(bus.bellek_adres_o);
    end else begin
      bus.bellek_veri_gecerli_i = 1'b0;
      bus.bellek_veri_i         = 32'h0;
    end
  end

  // Issues one request from a negedge and ends at the negedge of the response cycle.
  task automatic do_fetch(input logic [31:0] a, input bit exp_hit, input string nm);
    int cyc;
    cyc = 0;
    while (!bus.hazir_o && cyc < 100) begin @(negedge clk); cyc++; end
    check({nm, " ready"}, {31'b0, bus.hazir_o}, 32'd1);
    bus.ps_i = a;
    bus.ps_gecerli_i = 1'b1;
    @(negedge clk);
    bus.ps_gecerli_i = 1'b0;
    check({nm, " hit/miss"}, {30'b0, bus.buyruk_gecerli_o, bus.bellek_istek_o},
          exp_hit ? 32'd2 : 32'd1);
    if (!exp_hit) begin
      check({nm, " first beat addr"}, bus.bellek_adres_o, {a[31:4], 4'h0});
      cyc = 0;
      while (!bus.buyruk_gecerli_o && cyc < 300) begin @(negedge clk); cyc++; end
      check({nm, " response"}, {31'b0, bus.buyruk_gecerli_o}, 32'd1);
    end
    check({nm, " word"}, bus.buyruk_o, mem_word(a));
    check({nm, " ready after"}, {31'b0, bus.hazir_o}, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps_i = 32'h0;
    bus.ps_gecerli_i = 1'b0;
    bus.gecersiz_kil_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", {28'b0, bus.hazir_o, bus.buyruk_gecerli_o, bus.bellek_istek_o, 1'b0}, 32'd0);
    check("reset buyruk", bus.buyruk_o, 32'h0);
    check("reset addr", bus.bellek_adres_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", {31'b0, bus.hazir_o}, 32'd1);

    // Cold miss at 0x100 with a beat every cycle.
    bus.ps_i = 32'h100;
    bus.ps_gecerli_i = 1'b1;
    @(negedge clk);
    bus.ps_gecerli_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cold beat%0d addr", k), bus.bellek_adres_o, 32'h100 + 32'(4 * k));
      check($sformatf("cold beat%0d flags", k),
            {29'b0, bus.hazir_o, bus.buyruk_gecerli_o, bus.bellek_istek_o}, 32'd1);
      @(negedge clk);
    end
    check("cold N+5 valid/ready", {30'b0, bus.buyruk_gecerli_o, bus.hazir_o}, 32'd3);
    check("cold N+5 word", bus.buyruk_o, 32'h11111111);

    // Back-to-back hits, including an unaligned address.
    tablo[0] = '{32'h104, 32'h22222222};
    tablo[1] = '{32'h108, 32'h33333333};
    tablo[2] = '{32'h10C, 32'h44444444};
    tablo[3] = '{32'h10A, 32'h33333333};
    tablo[4] = '{32'h100, 32'h11111111};
    bus.ps_i = tablo[0].adres;
    bus.ps_gecerli_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b %h flags", tablo[i].adres),
            {29'b0, bus.buyruk_gecerli_o, bus.hazir_o, bus.bellek_istek_o}, 32'd6);
      check($sformatf("b2b %h word", tablo[i].adres), bus.buyruk_o, tablo[i].kelime);
      if (i < 4) bus.ps_i = tablo[i + 1].adres;
      else       bus.ps_gecerli_i = 1'b0;
    end

    // Conflict on the same index.
    do_fetch(32'h500, 1'b0, "conflict 0x500");
    do_fetch(32'h100, 1'b0, "refetch 0x100");

    // Invalidate together with a request: not accepted, retry misses.
    bus.gecersiz_kil_i = 1'b1;
    bus.ps_i = 32'h104;
    bus.ps_gecerli_i = 1'b1;
    #1 check("inval blocks ready", {31'b0, bus.hazir_o}, 32'd0);
    @(negedge clk);
    check("inval no accept", {30'b0, bus.buyruk_gecerli_o, bus.bellek_istek_o}, 32'd0);
    bus.gecersiz_kil_i = 1'b0;
    bus.ps_gecerli_i = 1'b0;
    do_fetch(32'h104, 1'b0, "retry 0x104");

    // Invalidate during a refill: response still delivered, block then misses.
    bus.ps_i = 32'h308;
    bus.ps_gecerli_i = 1'b1;
    @(negedge clk);
    bus.ps_gecerli_i = 1'b0;
    bus.gecersiz_kil_i = 1'b1;
    @(negedge clk);
    bus.gecersiz_kil_i = 1'b0;
    for (int c = 0; c < 20 && !bus.buyruk_gecerli_o; c++) @(negedge clk);
    check("fill+inval response", {31'b0, bus.buyruk_gecerli_o}, 32'd1);
    check("fill+inval word", bus.buyruk_o, mem_word(32'h308));
    do_fetch(32'h30C, 1'b0, "after fill+inval");

    // Stalled refill aborted by reset after two beats.
    @(posedge clk);
    mem_on = 1'b0;
    @(negedge clk);
    bus.gecersiz_kil_i = 1'b1;
    @(negedge clk);
    bus.gecersiz_kil_i = 1'b0;
    bus.ps_i = 32'h100;
    bus.ps_gecerli_i = 1'b1;
    @(negedge clk);
    bus.ps_gecerli_i = 1'b0;
    check("stall start addr", bus.bellek_adres_o, 32'h100);
    @(posedge clk);
    mem_on = 1'b1;
    repeat (2) @(posedge clk);
    mem_on = 1'b0;
    repeat (3) @(negedge clk);
    check("stall after 2 beats addr", bus.bellek_adres_o, 32'h108);
    check("stall req held", {31'b0, bus.bellek_istek_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort flags", {29'b0, bus.hazir_o, bus.buyruk_gecerli_o, bus.bellek_istek_o}, 32'd0);
    check("abort addr", bus.bellek_adres_o, 32'h0);
    check("abort buyruk", bus.buyruk_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_on = 1'b1;
    do_fetch(32'h100, 1'b0, "post-abort 0x100");
    do_fetch(32'h108, 1'b1, "post-abort hit 0x108");

    // Randomized traffic with memory stalls against the line model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    stall_pct = 30;
    @(negedge clk);
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int          idx;
      bit          hit;
      if ($urandom_range(0, 19) == 0) begin
        bus.gecersiz_kil_i = 1'b1;
        @(negedge clk);
        bus.gecersiz_kil_i = 1'b0;
        model_clear();
      end
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2)  |  32'($urandom_range(0, 3));
      idx = int'(a[9:4]);
      hit = m_gecerli[idx] && (m_etiket[idx] == a[31:10]);
      do_fetch(a, hit, $sformatf("rnd%0d %h", n, a));
      m_gecerli[idx] = 1'b1;
      m_etiket[idx]  = a[31:10];
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
